// File: rtl/ccr_pkg.sv
// Shared constants and types for the condition-code register controller.
package ccr_pkg;

  localparam int unsigned FLAG_W = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned COND_W = 2;

  // CCR bit positions
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  // ALU opcode encoding
  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SETC = 4'b0001;
  localparam logic [OP_W-1:0] OP_CLRC = 4'b0010;
  localparam logic [OP_W-1:0] OP_RSV3 = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0100;
  localparam logic [OP_W-1:0] OP_INC  = 4'b0101;
  localparam logic [OP_W-1:0] OP_DEC  = 4'b0110;
  localparam logic [OP_W-1:0] OP_MOV  = 4'b0111;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b1001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1011;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b1100;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1101;
  localparam logic [OP_W-1:0] OP_RSVE = 4'b1110;
  localparam logic [OP_W-1:0] OP_RSVF = 4'b1111;

  // Jump conditions
  localparam logic [COND_W-1:0] COND_JZ  = 2'b00;
  localparam logic [COND_W-1:0] COND_JN  = 2'b01;
  localparam logic [COND_W-1:0] COND_JC  = 2'b10;
  localparam logic [COND_W-1:0] COND_JMP = 2'b11;

  // Interrupt flag save/restore sequencer states
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SAVE    = 2'b01,
    ISR     = 2'b10,
    RESTORE = 2'b11
  } ccr_state_e;

endpackage

// File: rtl/ccr_update_mask.sv
// Opcode to CCR write-mask decode; also reused by the hazard unit.
module ccr_update_mask
  import ccr_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  output logic [FLAG_W-1:0] o_mask
);

  // Which CCR bits the retiring opcode is allowed to write
  always_comb begin
    o_mask = '0;
    case (i_op)
      OP_SETC, OP_CLRC:                      o_mask = FLAG_W'(3'b100);
      OP_NOT, OP_DEC, OP_SUB, OP_AND, OP_OR: o_mask = FLAG_W'(3'b011);
      OP_INC, OP_ADD, OP_SHL, OP_SHR:        o_mask = FLAG_W'(3'b111);
      default:                               o_mask = '0;
    endcase
  end

endmodule

// File: rtl/ccr_controller.sv
// Condition-code register owner: masked flag commit, jump evaluation with
// consumed-flag clear, and one-deep flag save/restore around interrupts.
module ccr_controller
  import ccr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_valid,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FLAG_W-1:0] alu_flag,
  input  logic              jmp_valid,
  input  logic [COND_W-1:0] jmp_cond,
  input  logic              stall,
  input  logic              int_req,
  input  logic              rti_valid,
  output logic [FLAG_W-1:0] flags,
  output logic              jmp_taken,
  output logic              int_ack,
  output logic              in_isr
);

  ccr_state_e        r_state;
  ccr_state_e        w_state_nxt;
  logic [FLAG_W-1:0] r_flags;
  logic [FLAG_W-1:0] r_shadow;
  logic              r_pending;
  logic              r_int_ack;
  logic              r_in_isr;
  logic              w_int_ack_d;
  logic              w_in_isr_d;
  logic [FLAG_W-1:0] w_mask;
  logic [FLAG_W-1:0] w_data;
  logic [FLAG_W-1:0] w_clr;
  logic [FLAG_W-1:0] w_flags_upd;
  logic              w_jmp_taken;

  ccr_update_mask u_mask (
    .i_op   (alu_op),
    .o_mask (w_mask)
  );

  // Write data: SETC/CLRC carry their own C value, everything else uses ALU flags
  always_comb begin
    w_data = alu_flag;
    if (alu_op == OP_SETC) begin
      w_data[FLAG_C] = 1'b1;
    end else if (alu_op == OP_CLRC) begin
      w_data[FLAG_C] = 1'b0;
    end
  end

  // Jump decision from the registered CCR and the bit a taken jump consumes
  always_comb begin
    w_jmp_taken = 1'b0;
    w_clr       = '0;
    case (jmp_cond)
      COND_JZ: begin
        w_jmp_taken   = jmp_valid & r_flags[FLAG_Z];
        w_clr[FLAG_Z] = w_jmp_taken;
      end
      COND_JN: begin
        w_jmp_taken   = jmp_valid & r_flags[FLAG_N];
        w_clr[FLAG_N] = w_jmp_taken;
      end
      COND_JC: begin
        w_jmp_taken   = jmp_valid & r_flags[FLAG_C];
        w_clr[FLAG_C] = w_jmp_taken;
      end
      default: begin
        w_jmp_taken = jmp_valid;
      end
    endcase
  end

  // Commit mask first, then the jump clear wins on its one bit
  always_comb begin
    w_flags_upd = r_flags;
    if (commit_valid) begin
      w_flags_upd = (r_flags & ~w_mask) | (w_data & w_mask);
    end
    w_flags_upd = w_flags_upd & ~w_clr;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (int_req && !stall) w_state_nxt = SAVE;
      SAVE:    w_state_nxt = ISR;
      ISR:     if (rti_valid) w_state_nxt = RESTORE;
      RESTORE: w_state_nxt = r_pending ? SAVE : RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM outputs, decoded from the next state so they register in step with it
  always_comb begin
    w_int_ack_d = 1'b0;
    w_in_isr_d  = 1'b0;
    case (w_state_nxt)
      SAVE:    w_int_ack_d = 1'b1;
      ISR:     w_in_isr_d  = 1'b1;
      default: begin
        w_int_ack_d = 1'b0;
        w_in_isr_d  = 1'b0;
      end
    endcase
  end

  // CCR, shadow copy, pending interrupt and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_int_ack <= 1'b0;
      r_in_isr  <= 1'b0;
    end else begin
      r_int_ack <= w_int_ack_d;
      r_in_isr  <= w_in_isr_d;
      if (r_state == RESTORE) begin
        r_flags <= r_shadow;
      end else begin
        r_flags <= w_flags_upd;
      end
      if (r_state == SAVE) begin
        r_shadow <= w_flags_upd;
      end
      if (r_state == RESTORE) begin
        r_pending <= 1'b0;
      end else if (r_state == ISR && int_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign flags     = r_flags;
  assign jmp_taken = w_jmp_taken;
  assign int_ack   = r_int_ack;
  assign in_isr    = r_in_isr;

endmodule

// File: tb/tb_ccr_controller.sv
// Scoreboard bench for ccr_controller: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
module tb_ccr_controller;
  import ccr_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              commit_valid;
  logic [OP_W-1:0]   alu_op;
  logic [FLAG_W-1:0] alu_flag;
  logic              jmp_valid;
  logic [COND_W-1:0] jmp_cond;
  logic              stall;
  logic              int_req;
  logic              rti_valid;
  logic [FLAG_W-1:0] flags;
  logic              jmp_taken;
  logic              int_ack;
  logic              in_isr;

  typedef struct {
    string             name;
    logic [FLAG_W-1:0] f;
    logic              jt;
    logic              ack;
    logic              isr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ccr_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .alu_op       (alu_op),
    .alu_flag     (alu_flag),
    .jmp_valid    (jmp_valid),
    .jmp_cond     (jmp_cond),
    .stall        (stall),
    .int_req      (int_req),
    .rti_valid    (rti_valid),
    .flags        (flags),
    .jmp_taken    (jmp_taken),
    .int_ack      (int_ack),
    .in_isr       (in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [FLAG_W-1:0] got, input logic [FLAG_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b", name, field, got, want);
    end
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "flags",     flags,                e.f);
      chk(e.name, "jmp_taken", FLAG_W'(jmp_taken),   FLAG_W'(e.jt));
      chk(e.name, "int_ack",   FLAG_W'(int_ack),     FLAG_W'(e.ack));
      chk(e.name, "in_isr",    FLAG_W'(in_isr),      FLAG_W'(e.isr));
    end
  end

  // Apply one cycle of stimulus just after the rising edge and queue the
  // outputs expected at the following falling edge.
  task automatic cyc(input logic rn, input logic cv, input logic [OP_W-1:0] op,
                     input logic [FLAG_W-1:0] af, input logic jv,
                     input logic [COND_W-1:0] jc, input logic st, input logic ir,
                     input logic rt, input string name,
                     input logic [FLAG_W-1:0] ef, input logic ejt,
                     input logic eack, input logic eisr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rn;
    commit_valid = cv;
    alu_op       = op;
    alu_flag     = af;
    jmp_valid    = jv;
    jmp_cond     = jc;
    stall        = st;
    int_req      = ir;
    rti_valid    = rt;
    e.name = name;
    e.f    = ef;
    e.jt   = ejt;
    e.ack  = eack;
    e.isr  = eisr;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; commit_valid = 1'b0; alu_op = '0; alu_flag = '0;
    jmp_valid = 1'b0; jmp_cond = '0; stall = 1'b0; int_req = 1'b0; rti_valid = 1'b0;

    //  rn  cv  op       af      jv  jc        st  ir  rt  name           flags   jt  ack isr
    cyc(0, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "reset",        3'b000, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 1, COND_JMP, 0, 0, 0, "jmp_at_reset", 3'b000, 1, 0, 0);
    cyc(1, 1, OP_ADD,  3'b101, 0, COND_JZ,  0, 0, 0, "add_issue",    3'b000, 0, 0, 0);
    cyc(1, 1, OP_MOV,  3'b010, 0, COND_JZ,  0, 0, 0, "add_commit",   3'b101, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "mov_nochange", 3'b101, 0, 0, 0);
    cyc(1, 1, OP_ADD,  3'b001, 0, COND_JZ,  0, 0, 0, "set_z_issue",  3'b101, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 1, COND_JZ,  0, 0, 0, "jz_taken",     3'b001, 1, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 1, COND_JC,  0, 0, 0, "jc_untaken",   3'b000, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "untaken_hold", 3'b000, 0, 0, 0);
    cyc(1, 1, OP_SETC, 3'b000, 0, COND_JZ,  0, 0, 0, "setc_issue",   3'b000, 0, 0, 0);
    cyc(1, 1, OP_INC,  3'b111, 1, COND_JC,  0, 0, 0, "inc_and_jc",   3'b100, 1, 0, 0);
    cyc(1, 1, OP_SHR,  3'b110, 0, COND_JZ,  0, 0, 0, "clear_wins",   3'b011, 0, 0, 0);
    cyc(1, 1, OP_NOT,  3'b001, 0, COND_JZ,  0, 0, 0, "shr_commit",   3'b110, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 1, COND_JN,  0, 0, 0, "not_zn_only",  3'b101, 0, 0, 0);
    cyc(1, 1, OP_AND,  3'b000, 0, COND_JZ,  0, 0, 0, "and_issue",    3'b101, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  1, 1, 0, "stall_1",      3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  1, 1, 0, "stall_2",      3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  1, 1, 0, "stall_3",      3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 1, 0, "unstall",      3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "save_ack",     3'b100, 0, 1, 0);
    cyc(1, 1, OP_SUB,  3'b001, 0, COND_JZ,  0, 0, 0, "isr_enter",    3'b100, 0, 0, 1);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "isr_sub",      3'b101, 0, 0, 1);
    cyc(1, 1, OP_CLRC, 3'b000, 0, COND_JZ,  0, 0, 1, "rti_clrc",     3'b101, 0, 0, 1);
    cyc(1, 1, OP_ADD,  3'b011, 0, COND_JZ,  0, 0, 0, "restore_st",   3'b001, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 1, "restore_wins", 3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 1, 0, "rti_ignored",  3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "save_ack2",    3'b100, 0, 1, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 1, 0, "isr_pend",     3'b100, 0, 0, 1);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 1, "isr_rti",      3'b100, 0, 0, 1);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "restore_pend", 3'b100, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "resave_ack",   3'b100, 0, 1, 0);
    cyc(1, 1, OP_ADD,  3'b010, 0, COND_JZ,  0, 0, 0, "isr_again",    3'b100, 0, 0, 1);
    cyc(0, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "async_reset",  3'b000, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 0, COND_JZ,  0, 0, 0, "post_reset",   3'b000, 0, 0, 0);
    cyc(1, 0, OP_NOP,  3'b000, 1, COND_JZ,  0, 0, 0, "post_reset2",  3'b000, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccr_controller.md
Name: ccr_controller

Overview:
- Owns the processor's condition-code register (CCR: Z, N, C), which lives outside the combinational ALU.
- Commits ALU-produced flags per opcode with a per-op update mask.
- Evaluates conditional jumps and clears the consumed flag.
- Sequences a one-deep flag save/restore around interrupts (save on entry, restore on RTI). Sits at the EX/MEM boundary; the hazard unit and the fetch stage consume its outputs.

Parameters:
- FLAG_W, 3, CCR width; bit0 = Z, bit1 = N, bit2 = C.
- OP_W, 4, ALU operation code width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- commit_valid  input  1  an ALU result retires this cycle.
- alu_op  input  OP_W  opcode of the retiring ALU operation.
- alu_flag  input  FLAG_W  raw flags from the ALU for that operation.
- jmp_valid  input  1  a jump is resolving this cycle.
- jmp_cond  input  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- stall  input  1  pipeline frozen; blocks interrupt entry only.
- int_req  input  1  interrupt request (level or pulse).
- rti_valid  input  1  RTI retiring.
- flags  output  FLAG_W  current CCR.
- jmp_taken  output  1  combinational jump decision.
- int_ack  output  1  one-cycle pulse on interrupt entry.
- in_isr  output  1  high while in ISR state.

Behaviour:
- Reset (rst_n low, async): flags=000, shadow=000, state=RUN, pending=0, int_ack=0, in_isr=0. jmp_taken is then 0 unless jmp_valid with cond 11.
- Update masks, applied when commit_valid=1:
  - SETC 0001: C<=1.
  - CLRC 0010: C<=0.
  - NOT 0100, DEC 0110, SUB 1001, AND 1010, OR 1011: Z,N <= alu_flag[1:0].
  - INC 0101, ADD 1000, SHL 1100, SHR 1101: Z,N,C <= alu_flag.
  - MOV 0111, 1110, 1111, 0000, 0011: no change.
  - Unmasked bits hold their value.
- Commit latency: flags reflect a commit one cycle after the commit edge. There is no same-cycle bypass; the hazard unit stalls.
- Jump evaluation (combinational):
  - jmp_taken = jmp_valid & (cond11 | selected flag of the registered CCR).
  - A taken conditional jump clears its tested bit at the next edge.
  - JMP clears nothing. An untaken jump clears nothing.
- Same-cycle commit and jump-clear: apply the commit mask first, then force the tested bit to 0 (clear wins on that bit only).
- States:
  - RUN: if int_req & ~stall, go to SAVE.
  - SAVE (one cycle):
    - shadow <= flags as updated this cycle (commit/clear included).
    - int_ack=1; go to ISR.
  - ISR:
    - in_isr=1; commits and jumps continue to update flags.
    - int_req sets pending (nesting not allowed).
    - On rti_valid go to RESTORE.
  - RESTORE (one cycle):
    - flags <= shadow, overriding any commit or clear this cycle.
    - If pending, clear pending and go to SAVE; else go to RUN.
- int_req while stall=1 in RUN is held off: the FSM stays in RUN; no latching, since the request is level.
- rti_valid outside ISR is ignored.
- Reset mid-SAVE/ISR/RESTORE returns to RUN, discarding shadow and pending.
- in_isr is registered; it is high in SAVE-exit → ISR only, and low in RESTORE.

Decomposition:
- Shared package (ccr_pkg):
  - Flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2.
  - ALU opcode constants (matching the ALU encoding above).
  - Jump condition constants.
  - FSM state enum {RUN, SAVE, ISR, RESTORE}.
- One sub-module: ccr_update_mask, a combinational mapping from opcode to 3-bit write mask. It is shared later with the hazard unit.

Test Plan:
1. Reset, then commit ADD with alu_flag=101 → flags=101 next cycle. Then commit MOV with alu_flag=010 → flags stays 101.
2. flags=001 (Z), jmp_valid, cond=00 → jmp_taken=1 the same cycle, and flags=000 next cycle. Then cond=10 with C=0 → jmp_taken=0, flags unchanged.
3. Same cycle: commit INC with alu_flag=111 and a taken JC → flags=011 next cycle (C cleared, Z/N committed).
4. flags=100, int_req=1 with stall=1 for 3 cycles → no int_ack. Drop stall → int_ack pulses once, in_isr=1, shadow=100.
5. In ISR: commit SUB with alu_flag=001 → flags=101. Assert rti_valid together with commit CLRC → flags=100 after RESTORE (restore wins), in_isr=0.
6. int_req asserted in ISR → after RTI, RESTORE goes directly to SAVE and int_ack pulses again. Assert rst_n=0 mid-ISR → all outputs reset asynchronously.
